ps2_key_ctrl: RTL and testbench

Sequencing controller between the `ps2_if` receive FIFO and the game logic. It pops scan-code bytes from the FIFO with a registered two-phase read handshake, and decodes set-2 make, break and extended (`E0`) sequences into single key events. It also tracks held state for the four game keys. It replaces the ad-hoc read/decode logic in the top level and drives `TETRIS_GAME`'s `ps2`/`ps2_en` inputs.

---
 rtl/ps2_key_ctrl.sv | 143 ++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 set-2 scan-code reader/decoder with held-key tracking.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN (suppress repeated extended makes of held keys).
module ps2_key_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 2500000,
    parameter logic [7:0]  KEY_LEFT    = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT   = 8'h74,
    parameter logic [7:0]  KEY_DOWN    = 8'h72,
    parameter logic [7:0]  KEY_ROT     = 8'h75
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic [3:0] keys_held,
    output logic       err_timeout
);

    typedef enum logic {RD_IDLE = 1'b0, RD_POP = 1'b1} rd_state_t;
    typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

    localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYC - 1);

    rd_state_t  rd_state, rd_next;
    dec_state_t dec_state, dec_next;
    logic [7:0]  byte_r;
    logic [21:0] tmo_cnt;
    logic        emit, emit_ext, emit_brk, emit_ok, tmo_hit;
    logic        held_hit, track;
    logic [1:0]  held_idx;

    function automatic logic is_noise(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
               (b == 8'h00) || (b == 8'hFF) || (b == 8'hE1);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    // The RD_POP state is the pop strobe itself, so it can never repeat back to back.
    always_comb begin
        rd_next = RD_IDLE;
        if (rd_state == RD_IDLE && !fifo_empty)
            rd_next = RD_POP;
    end

    assign fifo_rd = (rd_state == RD_POP);

    always_comb begin
        dec_next = dec_state;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        tmo_hit  = 1'b0;
        if (rd_state == RD_POP) begin
            case (dec_state)
                DEC_IDLE: begin
                    if (byte_r == 8'hE0)      dec_next = DEC_E0;
                    else if (byte_r == 8'hF0) dec_next = DEC_F0;
                    else if (!is_noise(byte_r)) emit = 1'b1;
                end
                DEC_E0: begin
                    if (byte_r == 8'hF0) begin
                        dec_next = DEC_E0F0;
                    end else if (byte_r != 8'hE0) begin
                        dec_next = DEC_IDLE;
                        emit     = !is_fake_shift(byte_r);
                        emit_ext = 1'b1;
                    end
                end
                DEC_F0: begin
                    dec_next = DEC_IDLE;
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                default: begin
                    dec_next = DEC_IDLE;
                    emit     = !is_fake_shift(byte_r);
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
            endcase
        end else if (dec_state != DEC_IDLE && tmo_cnt == TMO_LAST) begin
            dec_next = DEC_IDLE;
            tmo_hit  = 1'b1;
        end
    end

    always_comb begin
        held_hit = 1'b1;
        held_idx = 2'd0;
        if (byte_r == KEY_LEFT)       held_idx = 2'd0;
        else if (byte_r == KEY_RIGHT) held_idx = 2'd1;
        else if (byte_r == KEY_DOWN)  held_idx = 2'd2;
        else if (byte_r == KEY_ROT)   held_idx = 2'd3;
        else                          held_hit = 1'b0;
        track   = emit && emit_ext && held_hit;
`ifdef PS2_TYPEMATIC_FILTER_EN
        emit_ok = emit && !(track && !emit_brk && keys_held[held_idx]);
`else
        emit_ok = emit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state    <= RD_IDLE;
            dec_state   <= DEC_IDLE;
            byte_r      <= 8'h00;
            tmo_cnt     <= 22'd0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_valid   <= 1'b0;
            keys_held   <= 4'b0000;
            err_timeout <= 1'b0;
        end else begin
            rd_state  <= rd_next;
            dec_state <= dec_next;
            if (rd_state == RD_IDLE && !fifo_empty)
                byte_r <= fifo_data;
            if (dec_next != dec_state || dec_state == DEC_IDLE)
                tmo_cnt <= 22'd0;
            else
                tmo_cnt <= tmo_cnt + 22'd1;
            key_valid   <= emit_ok;
            err_timeout <= tmo_hit;
            if (emit_ok) begin
                key_code  <= byte_r;
                key_ext   <= emit_ext;
                key_break <= emit_brk;
            end
            if (track)
                keys_held[held_idx] <= !emit_brk;
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - directed bench with a byte-level reference model of ps2_key_ctrl.
module tb_ps2_key_ctrl;

    localparam int TMO = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam int T3_EVENTS = 2;
`else
    localparam int T3_EVENTS = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic [3:0] keys_held;
    logic       err_timeout;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .key_valid(key_valid), .keys_held(keys_held), .err_timeout(err_timeout)
    );

    logic [7:0] fifo_q[$];

    // Reference model: pending-prefix flags plus age, last event and held bits.
    logic       m_rd = 1'b0, m_e0 = 1'b0, m_f0 = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_age = 0;
    logic       exp_kv = 1'b0, exp_tmo = 1'b0;
    logic [7:0] exp_code = 8'h00;
    logic       exp_ext = 1'b0, exp_brk = 1'b0;
    logic [3:0] m_held = 4'b0000;
    int         ev_cnt = 0, m_last_dec_cyc = 0, m_tmo_cyc = 0;

    int   cyc = 0, n_vec = 0, n_err = 0;
    int   dut_kv_cnt = 0, dut_tmo_cnt = 0, dut_kv_cyc = 0, dut_tmo_cyc = 0;
    logic prev_kv = 1'b0, prev_rd = 1'b0, chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int key_idx(input logic [7:0] c);
        case (c)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h72:   return 2;
            8'h75:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic m_emit(input logic [7:0] c, input logic x, input logic b);
        int  k;
        logic suppress;
        k = key_idx(c);
        suppress = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (x && k >= 0 && !b && m_held[k]) suppress = 1'b1;
`endif
        if (x && k >= 0) m_held[k] = !b;
        if (!suppress) begin
            exp_kv = 1'b1; exp_code = c; exp_ext = x; exp_brk = b;
            ev_cnt++;
        end
    endtask

    task automatic model_edge();
        logic       popping;
        logic [1:0] old_pfx;
        logic [7:0] b;
        popping = m_rd;
        exp_kv  = 1'b0;
        exp_tmo = 1'b0;
        if (popping && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (rst) begin
            m_rd = 1'b0; m_e0 = 1'b0; m_f0 = 1'b0; m_age = 0;
            exp_code = 8'h00; exp_ext = 1'b0; exp_brk = 1'b0; m_held = 4'b0000;
            return;
        end
        if (popping) begin
            b = m_byte;
            old_pfx = {m_e0, m_f0};
            m_last_dec_cyc = cyc;
            if (m_f0) begin
                if (!(m_e0 && (b == 8'h12 || b == 8'h59))) m_emit(b, m_e0, 1'b1);
                m_e0 = 1'b0; m_f0 = 1'b0;
            end else if (b == 8'hF0) begin
                m_f0 = 1'b1;
            end else if (b == 8'hE0) begin
                m_e0 = 1'b1;
            end else if (m_e0) begin
                if (!(b == 8'h12 || b == 8'h59)) m_emit(b, 1'b1, 1'b0);
                m_e0 = 1'b0;
            end else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1})) begin
                m_emit(b, 1'b0, 1'b0);
            end
            if ({m_e0, m_f0} != old_pfx) m_age = 0;
            else if (m_e0 || m_f0)       m_age++;
        end else if (m_e0 || m_f0) begin
            if (m_age == TMO - 1) begin
                m_e0 = 1'b0; m_f0 = 1'b0; m_age = 0;
                exp_tmo = 1'b1; m_tmo_cyc = cyc;
            end else begin
                m_age++;
            end
        end
        m_rd = !popping && !fifo_empty;
        if (m_rd) m_byte = fifo_data;
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        drive_fifo();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fifo_rd", fifo_rd, m_rd);
            chk("key_valid", key_valid, exp_kv);
            chk("key_code", key_code, exp_code);
            chk("key_ext", key_ext, exp_ext);
            chk("key_break", key_break, exp_brk);
            chk("keys_held", keys_held, m_held);
            chk("err_timeout", err_timeout, exp_tmo);
            chk("kv_back_to_back", key_valid & prev_kv, 0);
            chk("rd_back_to_back", fifo_rd & prev_rd, 0);
            prev_kv = key_valid;
            prev_rd = fifo_rd;
            if (key_valid === 1'b1) begin dut_kv_cnt++; dut_kv_cyc = cyc; end
            if (err_timeout === 1'b1) begin dut_tmo_cnt++; dut_tmo_cyc = cyc; end
        end
    end

    initial begin
        int p, kv0, ev0, tm0, d;
        rst = 1'b1;
        drive_fifo();
        tick();
        chk_en = 1'b1;
        run(2);
        chk("rst_key_code", key_code, 8'h00);
        chk("rst_keys_held", keys_held, 4'b0000);
        chk("rst_fifo_rd", fifo_rd, 0);
        rst = 1'b0;
        run(2);

        // Plain make, latency two edges after the byte appears.
        kv0 = dut_kv_cnt; ev0 = ev_cnt;
        send(8'h1C); p = cyc;
        run(6);
        chk("t1_latency", dut_kv_cyc - p, 2);
        chk("t1_dut_events", dut_kv_cnt - kv0, 1);
        chk("t1_model_events", ev_cnt - ev0, 1);
        chk("t1_code", key_code, 8'h1C);
        chk("t1_fifo_drained", fifo_q.size(), 0);

        // Extended left make then break.
        kv0 = dut_kv_cnt;
        send(8'hE0); send(8'h6B);
        run(8);
        chk("t2_make_held", keys_held, 4'b0001);
        chk("t2_model_held", m_held, 4'b0001);
        chk("t2_make_ext", {key_ext, key_break}, 2'b10);
        send(8'hE0); send(8'hF0); send(8'h6B);
        run(10);
        chk("t2_break_held", keys_held, 4'b0000);
        chk("t2_break_flags", {key_code, key_ext, key_break}, {8'h6B, 2'b11});
        chk("t2_dut_events", dut_kv_cnt - kv0, 2);

        // Typematic repeats of the rotate key.
        kv0 = dut_kv_cnt; ev0 = ev_cnt;
        send(8'hE0); send(8'h75);
        run(7);
        chk("t3_held_after_make", keys_held, 4'b1000);
        for (int i = 0; i < 2; i++) begin send(8'hE0); send(8'h75); end
        send(8'hE0); send(8'hF0); send(8'h75);
        run(20);
        chk("t3_dut_events", dut_kv_cnt - kv0, T3_EVENTS);
        chk("t3_model_events", ev_cnt - ev0, T3_EVENTS);
        chk("t3_held_end", keys_held, 4'b0000);

        // Prefix timeout.
        tm0 = dut_tmo_cnt; kv0 = dut_kv_cnt;
        send(8'hE0);
        run(3);
        d = m_last_dec_cyc;
        run(20);
        chk("t4_tmo_count", dut_tmo_cnt - tm0, 1);
        chk("t4_tmo_delay_dut", dut_tmo_cyc - d, 16);
        chk("t4_tmo_delay_model", m_tmo_cyc - d, 16);
        chk("t4_no_event", dut_kv_cnt - kv0, 0);
        send(8'h1C);
        run(6);
        chk("t4_after", {key_code, key_ext, key_break}, {8'h1C, 2'b00});

        // Noise and fake shifts produce nothing.
        kv0 = dut_kv_cnt; ev0 = ev_cnt;
        send(8'hAA); send(8'hFA); send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h12);
        run(18);
        chk("t5_dut_events", dut_kv_cnt - kv0, 0);
        chk("t5_model_events", ev_cnt - ev0, 0);
        chk("t5_model_prefix", {m_e0, m_f0}, 2'b00);
        chk("t5_held", keys_held, 4'b0000);
        send(8'h7A);
        run(6);
        chk("t5_idle_after", {key_code, key_ext, key_break}, {8'h7A, 2'b00});

        // Reset in the middle of a break prefix.
        send(8'hF0);
        run(3);
        chk("t6_model_in_f0", m_f0, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_outputs", {key_code, key_ext, key_break, key_valid, err_timeout}, 12'h000);
        rst = 1'b0;
        send(8'h1C);
        run(6);
        chk("t6_make_after_rst", {key_code, key_ext, key_break}, {8'h1C, 2'b00});

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
